// File: rtl/ripple_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ripple_ctrl_pkg
// Brief    : Shared state encoding, direction codes and defaults for the
//            ripple counter run controller.
// Revision : 1.0 - initial release
// ============================================================================
package ripple_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int DEF_W          = 4;
    localparam int DEF_SETTLE_CYC = 2;

endpackage
`default_nettype wire

// File: rtl/run_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : run_step_timer
// Brief    : Loadable down-counter used for both the RUN step budget and the
//            SETTLE wait; saturates at zero.
// Revision : 1.0 - initial release
// ============================================================================
module run_step_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);
    assign o_last = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/ripple_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ripple_counter_ctrl
// Brief    : Sequences T/C/reset of a T-type up/down ripple counter so it takes
//            exactly the steps needed to reach a commanded target, then checks it.
// Revision : 1.0 - initial release
// ============================================================================
module ripple_counter_ctrl
    import ripple_ctrl_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_dir,
    input  logic         cmd_clear,
    input  logic [W-1:0] cmd_target,
    input  logic         abort,
    output logic         cnt_t,
    output logic         cnt_c,
    output logic         cnt_reset,
    input  logic [W-1:0] cnt_q,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] done_q,
    output logic         mismatch,
    output logic         aborted
);

    localparam logic [W:0] c_settle_val = (W+1)'(SETTLE_CYC);

    state_t       r_state;
    logic         r_dir;
    logic [W-1:0] r_target;
    logic         r_run_abort;

    logic [W-1:0] w_start;
    logic [W-1:0] w_n_idle;
    logic [W-1:0] w_n_clear;
    logic         w_tmr_load;
    logic         w_tmr_dec;
    logic [W:0]   w_tmr_val;
    logic         w_tmr_zero;
    logic         w_tmr_last;

    // While the counter is being reset this cycle, its value at the edge is 0.
    assign w_start   = cnt_reset ? '0 : cnt_q;
    assign w_n_idle  = cmd_dir ? (cmd_target - w_start) : (w_start - cmd_target);
    assign w_n_clear = r_dir ? r_target : ({W{1'b0}} - r_target);

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_dec  = 1'b0;
        w_tmr_val  = c_settle_val;
        case (r_state)
            IDLE: begin
                if (cmd_valid && !cmd_clear) begin
                    w_tmr_load = 1'b1;
                    if (w_n_idle != '0) w_tmr_val = {1'b0, w_n_idle};
                end
            end
            CLEAR: begin
                w_tmr_load = 1'b1;
                if (!abort && (w_n_clear != '0)) w_tmr_val = {1'b0, w_n_clear};
            end
            RUN: begin
                if (abort || w_tmr_last || w_tmr_zero) w_tmr_load = 1'b1;
                else                                   w_tmr_dec  = 1'b1;
            end
            SETTLE:  w_tmr_dec = 1'b1;
            default: ;
        endcase
    end

    run_step_timer #(
        .WIDTH (W + 1)
    ) u_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero),
        .o_last     (w_tmr_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dir       <= DIR_UP;
            r_target    <= '0;
            r_run_abort <= 1'b0;
            cnt_t       <= 1'b0;
            cnt_c       <= DIR_UP;
            cnt_reset   <= 1'b1;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_q      <= '0;
            mismatch    <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    cnt_reset <= 1'b0;
                    done      <= 1'b0;
                    if (cmd_valid) begin
                        r_dir       <= cmd_dir;
                        r_target    <= cmd_target;
                        r_run_abort <= 1'b0;
                        cnt_c       <= cmd_dir;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (cmd_clear) begin
                            r_state   <= CLEAR;
                            cnt_reset <= 1'b1;
                        end else if (w_n_idle == '0) begin
                            r_state <= SETTLE;
                        end else begin
                            r_state <= RUN;
                            cnt_t   <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    cnt_reset <= 1'b0;
                    if (abort) begin
                        r_run_abort <= 1'b1;
                        r_state     <= SETTLE;
                    end else if (w_n_clear == '0) begin
                        r_state <= SETTLE;
                    end else begin
                        r_state <= RUN;
                        cnt_t   <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_run_abort <= 1'b1;
                        cnt_t       <= 1'b0;
                        r_state     <= SETTLE;
                    end else if (w_tmr_last || w_tmr_zero) begin
                        cnt_t   <= 1'b0;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_tmr_last || w_tmr_zero) begin
                        done_q   <= cnt_q;
                        aborted  <= r_run_abort;
                        mismatch <= !r_run_abort && (cnt_q != r_target);
                        done     <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    cnt_t     <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ripple_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ripple_counter_ctrl
// Brief    : Directed bench for ripple_counter_ctrl driving a behavioural
//            4-bit up/down counter with an optional step fault.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ripple_counter_ctrl;
    import ripple_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic       cmd_clear;
    logic [3:0] cmd_target;
    logic       abort;
    logic       cnt_t;
    logic       cnt_c;
    logic       cnt_reset;
    logic [3:0] cnt_q;
    logic       busy;
    logic       done;
    logic [3:0] done_q;
    logic       mismatch;
    logic       aborted;
    logic       fault;

    int n_cmp = 0;
    int n_err = 0;

    ripple_counter_ctrl #(
        .W          (4),
        .SETTLE_CYC (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_clear  (cmd_clear),
        .cmd_target (cmd_target),
        .abort      (abort),
        .cnt_t      (cnt_t),
        .cnt_c      (cnt_c),
        .cnt_reset  (cnt_reset),
        .cnt_q      (cnt_q),
        .busy       (busy),
        .done       (done),
        .done_q     (done_q),
        .mismatch   (mismatch),
        .aborted    (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model; a fault makes every step move by two.
    always_ff @(posedge clk) begin
        if (cnt_reset)  cnt_q <= 4'd0;
        else if (cnt_t) cnt_q <= cnt_c ? cnt_q + (fault ? 4'd2 : 4'd1)
                                       : cnt_q - (fault ? 4'd2 : 4'd1);
    end

    // Issues one command from an IDLE negedge and returns at the IDLE negedge after done.
    task automatic run_cmd(input logic dir, input logic clr, input logic [3:0] tgt,
                           input logic ab, output int steps, output int cycles,
                           output int clr_pulses, output int overlap,
                           output logic c_first, output logic to);
        steps = 0; cycles = 0; clr_pulses = 0; overlap = 0; c_first = 1'bx; to = 1'b1;
        cmd_valid = 1'b1; cmd_dir = dir; cmd_clear = clr; cmd_target = tgt; abort = ab;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycles++;
            if (cnt_t) begin
                if (steps == 0) c_first = cnt_c;
                steps++;
            end
            if (cnt_reset) clr_pulses++;
            if (cnt_t && cnt_reset) overlap++;
            if (done) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({cnt_t, cnt_c, cnt_reset, busy, cmd_ready, done, mismatch, aborted} !== 8'b0110_1000) begin
            n_err++; $display("FAIL reset_flags: got %b want 01101000",
                {cnt_t, cnt_c, cnt_reset, busy, cmd_ready, done, mismatch, aborted});
        end
        n_cmp++; if (done_q !== 4'd0) begin n_err++; $display("FAIL reset_done_q: got %0d want 0", done_q); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (cnt_reset !== 1'b0) begin n_err++; $display("FAIL reset_cnt_reset_drop: got %b want 0", cnt_reset); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_up_clear();
        int st, cy, cp, ov; logic cf, to;
        run_cmd(DIR_UP, 1'b1, 4'd5, 1'b0, st, cy, cp, ov, cf, to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL up_clear_timeout: got %b want 0", to); end
        n_cmp++; if (st !== 5) begin n_err++; $display("FAIL up_clear_steps: got %0d want 5", st); end
        n_cmp++; if (cp !== 1) begin n_err++; $display("FAIL up_clear_reset_pulse: got %0d want 1", cp); end
        n_cmp++; if (ov !== 0) begin n_err++; $display("FAIL up_clear_t_reset_overlap: got %0d want 0", ov); end
        n_cmp++; if (cy !== 9) begin n_err++; $display("FAIL up_clear_latency: got %0d want 9", cy); end
        n_cmp++; if ({done_q, mismatch, aborted} !== {4'd5, 2'b00}) begin
            n_err++; $display("FAIL up_clear_result: got q=%0d m=%b a=%b want q=5 m=0 a=0", done_q, mismatch, aborted);
        end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL up_clear_ready_after: got %b want 1", cmd_ready); end
    endtask

    task automatic test_down();
        int st, cy, cp, ov; logic cf, to;
        run_cmd(DIR_DN, 1'b0, 4'd2, 1'b0, st, cy, cp, ov, cf, to);
        n_cmp++; if (st !== 3) begin n_err++; $display("FAIL down_steps: got %0d want 3", st); end
        n_cmp++; if (cf !== 1'b0) begin n_err++; $display("FAIL down_dir_at_first_t: got %b want 0", cf); end
        n_cmp++; if (cy !== 6) begin n_err++; $display("FAIL down_latency: got %0d want 6", cy); end
        n_cmp++; if (cp !== 0) begin n_err++; $display("FAIL down_no_clear: got %0d want 0", cp); end
        n_cmp++; if ({done_q, mismatch, aborted} !== {4'd2, 2'b00}) begin
            n_err++; $display("FAIL down_result: got q=%0d m=%b a=%b want q=2 m=0 a=0", done_q, mismatch, aborted);
        end
    endtask

    task automatic test_wrap();
        int st, cy, cp, ov; logic cf, to;
        run_cmd(DIR_UP, 1'b0, 4'd14, 1'b0, st, cy, cp, ov, cf, to);
        n_cmp++; if (st !== 12 || done_q !== 4'd14) begin
            n_err++; $display("FAIL wrap_preset: got steps=%0d q=%0d want steps=12 q=14", st, done_q);
        end
        run_cmd(DIR_UP, 1'b0, 4'd2, 1'b0, st, cy, cp, ov, cf, to);
        n_cmp++; if (st !== 4) begin n_err++; $display("FAIL wrap_steps: got %0d want 4", st); end
        n_cmp++; if (done_q !== 4'd2 || mismatch !== 1'b0) begin
            n_err++; $display("FAIL wrap_result: got q=%0d m=%b want q=2 m=0", done_q, mismatch);
        end
        run_cmd(DIR_DN, 1'b0, 4'd2, 1'b0, st, cy, cp, ov, cf, to);
        n_cmp++; if (st !== 0) begin n_err++; $display("FAIL zero_dist_steps: got %0d want 0", st); end
        n_cmp++; if (cy !== 3) begin n_err++; $display("FAIL zero_dist_latency: got %0d want 3", cy); end
        n_cmp++; if (done_q !== 4'd2 || mismatch !== 1'b0) begin
            n_err++; $display("FAIL zero_dist_result: got q=%0d m=%b want q=2 m=0", done_q, mismatch);
        end
    endtask

    task automatic test_abort_run();
        int runc, st; logic seen;
        runc = 0; st = 0; seen = 1'b0;
        cmd_valid = 1'b1; cmd_dir = DIR_UP; cmd_clear = 1'b1; cmd_target = 4'd12;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cnt_t) runc++;
            if (runc == 3) break;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (cnt_t !== 1'b0) begin n_err++; $display("FAIL abort_run_t_drop: got %b want 0", cnt_t); end
        for (int i = 0; i < 50; i++) begin
            if (cnt_t) st++;
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL abort_run_done: got %b want 1", seen); end
        n_cmp++; if (runc + st !== 3) begin n_err++; $display("FAIL abort_run_steps: got %0d want 3", runc + st); end
        n_cmp++; if ({done_q, mismatch, aborted} !== {4'd3, 2'b01}) begin
            n_err++; $display("FAIL abort_run_result: got q=%0d m=%b a=%b want q=3 m=0 a=1", done_q, mismatch, aborted);
        end
        @(negedge clk);
    endtask

    task automatic test_abort_clear();
        int st; logic seen;
        st = 0; seen = 1'b0;
        cmd_valid = 1'b1; cmd_dir = DIR_UP; cmd_clear = 1'b1; cmd_target = 4'd9;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cnt_t) st++;
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b1 || st !== 0) begin
            n_err++; $display("FAIL abort_clear_run: got done=%b steps=%0d want done=1 steps=0", seen, st);
        end
        n_cmp++; if ({done_q, mismatch, aborted} !== {4'd0, 2'b01}) begin
            n_err++; $display("FAIL abort_clear_result: got q=%0d m=%b a=%b want q=0 m=0 a=1", done_q, mismatch, aborted);
        end
        @(negedge clk);
    endtask

    task automatic test_abort_idle();
        int st, cy, cp, ov; logic cf, to;
        run_cmd(DIR_UP, 1'b0, 4'd1, 1'b1, st, cy, cp, ov, cf, to);
        n_cmp++; if (st !== 1 || {done_q, aborted} !== {4'd1, 1'b0}) begin
            n_err++; $display("FAIL abort_idle_ignored: got steps=%0d q=%0d a=%b want steps=1 q=1 a=0", st, done_q, aborted);
        end
    endtask

    task automatic test_back_to_back();
        int rdy_busy, st; logic seen;
        rdy_busy = 0; st = 0; seen = 1'b0;
        cmd_valid = 1'b1; cmd_dir = DIR_UP; cmd_clear = 1'b0; cmd_target = 4'd3;
        @(negedge clk);
        cmd_target = 4'd6;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) rdy_busy++;
            if (cnt_t) st++;
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b1 || st !== 2) begin
            n_err++; $display("FAIL b2b_first: got done=%b steps=%0d want done=1 steps=2", seen, st);
        end
        n_cmp++; if (rdy_busy !== 0) begin n_err++; $display("FAIL b2b_ready_while_busy: got %0d want 0", rdy_busy); end
        @(negedge clk);
        n_cmp++; if ({cmd_ready, busy} !== 2'b10) begin
            n_err++; $display("FAIL b2b_idle_gap: got ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++; if ({cmd_ready, busy} !== 2'b01) begin
            n_err++; $display("FAIL b2b_second_accept: got ready=%b busy=%b want ready=0 busy=1", cmd_ready, busy);
        end
        st = 0; seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cnt_t) st++;
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b1 || st !== 3 || done_q !== 4'd6) begin
            n_err++; $display("FAIL b2b_second: got done=%b steps=%0d q=%0d want done=1 steps=3 q=6", seen, st, done_q);
        end
        @(negedge clk);
    endtask

    task automatic test_fault();
        int st, cy, cp, ov; logic cf, to;
        fault = 1'b1;
        run_cmd(DIR_UP, 1'b0, 4'd8, 1'b0, st, cy, cp, ov, cf, to);
        fault = 1'b0;
        n_cmp++; if (st !== 2) begin n_err++; $display("FAIL fault_steps: got %0d want 2", st); end
        n_cmp++; if ({done_q, mismatch, aborted} !== {4'd10, 2'b10}) begin
            n_err++; $display("FAIL fault_result: got q=%0d m=%b a=%b want q=10 m=1 a=0", done_q, mismatch, aborted);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done, n_clr;
        n_done = 0; n_clr = 0;
        cmd_valid = 1'b1; cmd_dir = DIR_UP; cmd_clear = 1'b0; cmd_target = 4'd15;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({cnt_t, busy, cmd_ready, cnt_reset, done} !== 5'b00110) begin
            n_err++; $display("FAIL midrun_reset: got t=%b busy=%b rdy=%b crst=%b done=%b want 0 0 1 1 0",
                cnt_t, busy, cmd_ready, cnt_reset, done);
        end
        n_cmp++; if (done_q !== 4'd0 || mismatch !== 1'b0) begin
            n_err++; $display("FAIL midrun_reset_result: got q=%0d m=%b want q=0 m=0", done_q, mismatch);
        end
        reset = 1'b0; cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) n_done++;
            if (cnt_reset) n_clr++;
        end
        n_cmp++; if (n_done !== 0 || n_clr !== 0) begin
            n_err++; $display("FAIL midrun_after: got done=%0d crst=%0d want 0 0", n_done, n_clr);
        end
    endtask

    task automatic test_after_reset();
        int st, cy, cp, ov; logic cf, to;
        run_cmd(DIR_DN, 1'b0, 4'd13, 1'b0, st, cy, cp, ov, cf, to);
        n_cmp++; if (st !== 3 || to !== 1'b0) begin
            n_err++; $display("FAIL down_wrap_steps: got %0d timeout=%b want 3 0", st, to);
        end
        n_cmp++; if ({done_q, mismatch, aborted} !== {4'd13, 2'b00}) begin
            n_err++; $display("FAIL down_wrap_result: got q=%0d m=%b a=%b want q=13 m=0 a=0", done_q, mismatch, aborted);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_clear = 1'b0;
        cmd_target = 4'd0; abort = 1'b0; fault = 1'b0;
        test_reset();
        test_up_clear();
        test_down();
        test_wrap();
        test_abort_run();
        test_abort_clear();
        test_abort_idle();
        test_back_to_back();
        test_fault();
        test_reset_mid_run();
        test_after_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
